// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the D-stage hazard
//                scoreboard: the shadow-stage entry layout, the
//                forward-select encoding for the register file, and the
//                default MDU latencies.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    // Default field widths of one shadow-pipeline entry.
    localparam int HZ_REG_AW    = 5;
    localparam int HZ_TNEW_W    = 2;

    // A forward select of zero means "take the register file value".
    localparam int FWD_RF       = 0;

    // Default MDU busy periods in cycles.
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // One in-flight instruction as seen by the hazard logic. The scoreboard
    // re-declares this layout locally with its own parameter widths; this
    // typedef is the default-width view for code outside the block.
    typedef struct packed {
        logic                 wr_en;
        logic [HZ_REG_AW-1:0] addr;
        logic [HZ_TNEW_W-1:0] tnew;
    } stage_entry_t;

endpackage
`default_nettype wire

// File: rtl/md_busy_timer.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_timer
//  Description : Multiply/divide unit busy countdown. Loads the mult or div
//                latency when an MDU op leaves D, then counts down to zero
//                and holds. busy is derived from the registered count only.
//  Revision    : 1.0  initial release
// ============================================================================
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic is_div,
    output logic busy
);

    logic [CNT_W-1:0] md_cnt;

    // Countdown register: load on issue, otherwise decrement and stick at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (load) begin
            md_cnt <= is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

    assign busy = (md_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Parametrised D-stage hazard unit. Keeps a shadow pipeline of
//                {wr_en, addr, tnew} for every in-flight instruction, finds
//                the youngest producer of each D source, and generates a
//                zero-latency stall plus D-stage forward selects. Also gates
//                MDU ops on an internal busy timer.
//                Optional macro HAZARD_STALL_CNT_EN adds a 32-bit stall_cnt
//                output counting stalled cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = HZ_REG_AW,
    parameter int TNEW_W   = HZ_TNEW_W,
    parameter int NSTAGE   = 3,
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4,
    parameter int SEL_W    = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic              d_wr_en,
    input  logic [REG_AW-1:0] d_wr_addr,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_md_use,
    input  logic              d_md_start,
    input  logic              d_md_div,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic              md_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    typedef struct packed {
        logic              wr_en;
        logic [REG_AW-1:0] addr;
        logic [TNEW_W-1:0] tnew;
    } entry_t;

    // Saturating one-cycle ageing of a T_new value.
    function automatic logic [TNEW_W-1:0] age_tnew(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    entry_t            stage_q [1:NSTAGE];
    logic [NSTAGE:1]   rs_hit;
    logic [NSTAGE:1]   rt_hit;

    logic              rs_found;
    logic              rt_found;
    logic [SEL_W-1:0]  rs_idx;
    logic [SEL_W-1:0]  rt_idx;
    logic [TNEW_W-1:0] rs_tnew;
    logic [TNEW_W-1:0] rt_tnew;

    logic              rs_stall;
    logic              rt_stall;
    logic              md_stall;
    logic              md_load;

    // Shadow pipeline: stage 1 takes D (or a bubble), older stages always age.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            if (stall || !d_valid) begin
                stage_q[1] <= '0;
            end else begin
                stage_q[1] <= '{wr_en: d_wr_en, addr: d_wr_addr, tnew: d_tnew};
            end
            for (int k = 2; k <= NSTAGE; k++) begin
                stage_q[k] <= '{wr_en: stage_q[k-1].wr_en,
                                addr:  stage_q[k-1].addr,
                                tnew:  age_tnew(stage_q[k-1].tnew)};
            end
        end
    end

    // Per-stage producer match; $0 is hard-wired and never has a producer.
    for (genvar k = 1; k <= NSTAGE; k++) begin : g_match
        assign rs_hit[k] = stage_q[k].wr_en && (stage_q[k].addr == d_rs) && (d_rs != '0);
        assign rt_hit[k] = stage_q[k].wr_en && (stage_q[k].addr == d_rt) && (d_rt != '0);
    end

    // Youngest-match priority: scan oldest to youngest so the lowest k wins.
    always_comb begin
        rs_found = 1'b0;
        rt_found = 1'b0;
        rs_idx   = SEL_W'(FWD_RF);
        rt_idx   = SEL_W'(FWD_RF);
        rs_tnew  = '0;
        rt_tnew  = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (rs_hit[k]) begin
                rs_found = 1'b1;
                rs_idx   = SEL_W'(k);
                rs_tnew  = stage_q[k].tnew;
            end
            if (rt_hit[k]) begin
                rt_found = 1'b1;
                rt_idx   = SEL_W'(k);
                rt_tnew  = stage_q[k].tnew;
            end
        end
    end

    // Stall decision and forward selects; a not-yet-ready producer is left
    // to the downstream forwarding path, so the D select stays at RF.
    always_comb begin
        rs_stall   = rs_found && (d_tuse_rs < rs_tnew);
        rt_stall   = rt_found && (d_tuse_rt < rt_tnew);
        md_stall   = d_valid && d_md_use && md_busy;
        stall      = d_valid && (rs_stall || rt_stall || md_stall);
        fwd_rs_sel = (rs_found && (rs_tnew == '0)) ? rs_idx : SEL_W'(FWD_RF);
        fwd_rt_sel = (rt_found && (rt_tnew == '0)) ? rt_idx : SEL_W'(FWD_RF);
        md_load    = d_valid && d_md_start && !stall;
    end

    md_busy_timer #(
        .CNT_W    (CNT_W),
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (md_load),
        .is_div (d_md_div),
        .busy   (md_busy)
    );

`ifdef HAZARD_STALL_CNT_EN
    // Free-running count of stalled cycles, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Self-checking bench for hazard_scoreboard. A list-based
//                reference model of in-flight writers and the MDU busy
//                period predicts stall / forward selects / md_busy each
//                cycle for directed scenarios and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NS   = 3;
    localparam int MULT = 5;
    localparam int DIV  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_wr_addr;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_wr_en, d_md_use, d_md_start, d_md_div;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_wr_en    (d_wr_en),
        .d_wr_addr  (d_wr_addr),
        .d_tnew     (d_tnew),
        .d_md_use   (d_md_use),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model: age-ordered list of in-flight instructions
    // (index 1 = just left D), remaining MDU busy cycles, stall tally.
    int m_we   [1:NS];
    int m_addr [1:NS];
    int m_tnew [1:NS];
    int m_cnt;
    int unsigned m_scnt;

    int e_stall, e_rs, e_rt, e_busy;
    int last_stall, last_rs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 1; k <= NS; k++) begin
            m_we[k] = 0; m_addr[k] = 0; m_tnew[k] = 0;
        end
        m_cnt  = 0;
        m_scnt = 0;
    endfunction

    // Find the youngest in-flight writer of src; 0 = none.
    function automatic void youngest(input int src, output int k_hit, output int tn);
        k_hit = 0;
        tn    = 0;
        if (src != 0) begin
            for (int k = 1; k <= NS; k++) begin
                if (m_we[k] != 0 && m_addr[k] == src) begin
                    k_hit = k;
                    tn    = m_tnew[k];
                    break;
                end
            end
        end
    endfunction

    function automatic void model_eval();
        int krs, tnrs, krt, tnrt;
        bit hz;
        youngest(int'(d_rs), krs, tnrs);
        youngest(int'(d_rt), krt, tnrt);
        hz = (krs != 0 && int'(d_tuse_rs) < tnrs) ||
             (krt != 0 && int'(d_tuse_rt) < tnrt) ||
             (d_md_use && m_cnt > 0);
        e_stall = (d_valid && hz) ? 1 : 0;
        e_rs    = (krs != 0 && tnrs == 0) ? krs : 0;
        e_rt    = (krt != 0 && tnrt == 0) ? krt : 0;
        e_busy  = (m_cnt > 0) ? 1 : 0;
    endfunction

    function automatic void model_clock();
        if (!reset) begin
            model_clear();
            return;
        end
        if (e_stall != 0) m_scnt++;
        for (int k = NS; k >= 2; k--) begin
            m_we[k]   = m_we[k-1];
            m_addr[k] = m_addr[k-1];
            m_tnew[k] = (m_tnew[k-1] > 0) ? m_tnew[k-1] - 1 : 0;
        end
        if (d_valid && e_stall == 0) begin
            m_we[1] = d_wr_en; m_addr[1] = int'(d_wr_addr); m_tnew[1] = int'(d_tnew);
        end else begin
            m_we[1] = 0; m_addr[1] = 0; m_tnew[1] = 0;
        end
        if (d_valid && d_md_start && e_stall == 0) m_cnt = d_md_div ? DIV : MULT;
        else if (m_cnt > 0) m_cnt--;
    endfunction

    task automatic drive(input bit v, input int rs, input int rt, input int urs, input int urt,
                         input bit we, input int wa, input int tn,
                         input bit mu, input bit ms, input bit md);
        d_valid = v; d_rs = 5'(rs); d_rt = 5'(rt);
        d_tuse_rs = 2'(urs); d_tuse_rt = 2'(urt);
        d_wr_en = we; d_wr_addr = 5'(wa); d_tnew = 2'(tn);
        d_md_use = mu; d_md_start = ms; d_md_div = md;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        model_eval();
        last_stall = int'(stall);
        last_rs    = int'(fwd_rs_sel);
        check("stall",      32'(stall),      32'(e_stall));
        check("fwd_rs_sel", 32'(fwd_rs_sel), 32'(e_rs));
        check("fwd_rt_sel", 32'(fwd_rt_sel), 32'(e_rt));
        check("md_busy",    32'(md_busy),    32'(e_busy));
`ifdef HAZARD_STALL_CNT_EN
        check("stall_cnt",  stall_cnt,       32'(m_scnt));
`endif
        @(posedge clk);
        model_clock();
        #1;
    endtask

    initial begin
        int n;
        int unsigned cnt0;
        model_clear();
        reset = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Load-use: lw $8 (tnew 2), then add using $8 at tuse 1.
        drive(1, 0, 0, 3, 3, 1, 8, 2, 0, 0, 0); tick();
        drive(1, 8, 0, 1, 3, 1, 10, 1, 0, 0, 0); tick();
        check("s1_stall_first", 32'(last_stall), 32'd1);
        tick();
        check("s1_stall_second", 32'(last_stall), 32'd0);
        idle(); tick(); tick(); tick();

        // Two writers of $9; the younger one governs.
        drive(1, 0, 0, 3, 3, 1, 9, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 3, 3, 1, 9, 1, 0, 0, 0); tick();
        drive(1, 9, 0, 0, 3, 0, 0, 0, 0, 0, 0); tick();
        check("s2_young_stall", 32'(last_stall), 32'd1);
        tick();
        check("s2_release", 32'(last_stall), 32'd0);
        idle(); tick(); tick(); tick();

        // mult then mflo held in D: stalls exactly MULT cycles.
`ifdef HAZARD_STALL_CNT_EN
        cnt0 = stall_cnt;
`else
        cnt0 = 0;
`endif
        drive(1, 4, 5, 0, 0, 0, 0, 0, 1, 1, 0); tick();
        drive(1, 0, 0, 3, 3, 1, 2, 1, 1, 0, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_stall == 0) break;
            n++;
        end
        check("mult_stall_len", 32'(n), 32'(MULT));
`ifdef HAZARD_STALL_CNT_EN
        check("stall_cnt_delta", stall_cnt - cnt0, 32'(MULT));
`else
        check("stall_cnt_delta", 32'(cnt0), 32'd0);
`endif
        // Back-to-back mult: the second one stalls MULT cycles too.
        drive(1, 4, 5, 0, 0, 0, 0, 0, 1, 1, 0); tick();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_stall == 0) break;
            n++;
        end
        check("b2b_mult_stall_len", 32'(n), 32'(MULT));
        idle();
        for (int i = 0; i < 6; i++) tick();

        // div, mflo waits, then reset asserted asynchronously mid-cycle.
        drive(1, 0, 0, 3, 3, 1, 7, 0, 1, 1, 1); tick();
        drive(1, 7, 7, 0, 0, 0, 0, 0, 1, 0, 0);
        tick(); tick(); tick();
        check("s4_pre_stall", 32'(last_stall), 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_stall",  32'(stall),      32'd0);
        check("rst_busy",   32'(md_busy),    32'd0);
        check("rst_fwd_rs", 32'(fwd_rs_sel), 32'd0);
        check("rst_fwd_rt", 32'(fwd_rt_sel), 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        tick();
        tick();
        reset = 1'b1;
        idle(); tick();

        // Writes to $0 never hazard; an invalid D never stalls.
        drive(1, 0, 0, 3, 3, 1, 0, 2, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        check("zero_reg_stall", 32'(last_stall), 32'd0);
        check("zero_reg_fwd",   32'(last_rs),    32'd0);
        drive(1, 0, 0, 3, 3, 1, 5, 2, 0, 0, 0); tick();
        drive(0, 5, 5, 0, 0, 0, 0, 0, 1, 0, 0); tick();
        check("invalid_no_stall", 32'(last_stall), 32'd0);
        idle(); tick(); tick(); tick();

        // Random traffic over a small register set to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            bit ms;
            ms = ($urandom_range(0, 15) == 0);
            drive($urandom_range(0, 7) != 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  ms || ($urandom_range(0, 7) == 0), ms, $urandom_range(0, 1) == 1);
            if (i == 200) begin
                @(negedge clk);
                #2 reset = 1'b0;
                #1;
                check("rand_rst_stall", 32'(stall), 32'd0);
                model_clear();
                @(posedge clk);
                #1;
                reset = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
`default_nettype wire
